mac_result_fifo: RTL
====================

// Module: mac_result_fifo
// PURPOSE
//   Downstream buffer for the a*b+c MAC stage: captures every result word the MAC presents
//   with a one-cycle valid pulse (valido/data_out) and hands it to a consumer over a
//   valid/ready handshake. The MAC cannot be stalled, so words that arrive while the buffer
//   is full are dropped, flagged sticky and counted. First-word-fall-through output.
// PARAMETERS
//   DATA_W   32  width of one result word; must match the MAC data_out
//   DEPTH    4   number of entries; power of two, >= 2
//   DROP_W   8   width of the saturating dropped-word counter
// PORTS
//   clk        in   1          single clock; all state updates on posedge clk
//   rst        in   1          synchronous, active-high reset
//   validi     in   1          MAC result valid (driven by MAC valido)
//   data_in    in   DATA_W     MAC result word (driven by MAC data_out)
//   ready_in   in   1          consumer accepts the head word this cycle
//   valido     out  1          head word available (= !empty)
//   data_out   out  DATA_W     head word; 0 whenever empty
//   count      out  clog2(DEPTH+1)  current occupancy, 0..DEPTH
//   full       out  1          count == DEPTH
//   empty      out  1          count == 0
//   clr_ovf    in   1          clears overflow and drop_cnt (synchronous)
//   overflow   out  1          sticky: at least one word dropped
//   drop_cnt   out  DROP_W     number of dropped words, saturates at all-ones
// BEHAVIOUR
//   - Reset (rst=1 at posedge): rd/wr pointers=0, count=0, overflow=0, drop_cnt=0.
//     Next cycle: valido=0, data_out=0, empty=1, full=0. rst overrides all other inputs.
//   - pop  = valido & ready_in. push = validi & (!full | pop).
//   - Write on push: mem[wr_ptr]<=data_in, wr_ptr++ (mod DEPTH). Read on pop: rd_ptr++.
//   - count: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
//   - Latency: word pushed at edge N is visible on data_out/valido after edge N
//     (i.e. in cycle N+1) when FIFO was empty; no combinational data_in->data_out path.
//   - Full + validi + pop same cycle: word accepted, count stays DEPTH, no drop.
//   - Full + validi + no pop: word discarded, memory/pointers unchanged,
//     overflow<=1, drop_cnt<=drop_cnt+1 (saturating at 2^DROP_W-1).
//   - Empty + ready_in: no pop, pointers unchanged, data_out stays 0.
//   - clr_ovf and a drop in the same cycle: drop wins (overflow=1, drop_cnt=1).
//   - Pointer wrap-around at DEPTH-1 -> 0 is transparent; ordering is strict FIFO.
//   - data_out = empty ? 0 : mem[rd_ptr]; valido, full, empty, count are decoded
//     from registered state only.
//   - No handshake ordering constraint on the consumer: ready_in may be asserted
//     before valido and may drop at any time; valido never depends on ready_in.
// STRUCTURE
//   - mac_pkg (shared): localparam MAC_DATA_W=32; typedef logic [MAC_DATA_W-1:0] mac_data_t.
//     The MAC stage and this block both import it.
//   - Optional sub-module: mac_fifo_mem (DEPTH x DATA_W register array, 1 write port,
//     1 async read port, no reset on storage). Pointer/count/flag logic stays in the top.
//   - Checker module mac_result_fifo_property (bind) in the same style as the MAC checker:
//     one `ifdef checkN per property, check-all macro enables all of them.
// TESTING
//   1. rst=1 for 2 cycles with validi=1, data_in=32'hFFFF -> valido=0, data_out=0,
//      count=0, overflow=0 throughout and one cycle after.
//   2. Push 5, 7, 9 with ready_in=0, then ready_in=1 -> data_out 5,7,9 on consecutive
//      cycles, count 3->2->1->0, empty=1 and data_out=0 afterwards.
//   3. DEPTH=4, ready_in=0, push 1..6 -> full=1 after 4th, data_out=1, overflow=1,
//      drop_cnt=2; drain yields 1,2,3,4 only.
//   4. Full FIFO, validi=1 with data_in=99 and ready_in=1 same cycle -> count stays 4,
//      overflow stays 0, 99 emerges 4th after current head.
//   5. Continuous push+pop for 10 words (100..109) -> pointers wrap twice, output order
//      100..109, count never exceeds 1.
//   6. 300 drops with ready_in=0 -> drop_cnt=255; clr_ovf=1 one cycle (no drop) ->
//      overflow=0, drop_cnt=0; mid-drain rst=1 -> empty next cycle, remaining words lost.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the a*b+c MAC stage and its downstream result buffer.
package mac_pkg;
  localparam int MAC_DATA_W = 32;
  typedef logic [MAC_DATA_W-1:0] mac_data_t;
endpackage

// File: rtl/mac_fifo_mem.sv
// Result-word storage: one write port, one asynchronous read port, no reset on contents.
module mac_fifo_mem
  import mac_pkg::*;
#(
  parameter int  DATA_W = MAC_DATA_W,
  parameter int  DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mac_result_fifo_property.sv
// Assertion checker for mac_result_fifo; each property has its own CHECKn macro and
// CHECK_ALL enables every property and binds the checker into the buffer.
module mac_result_fifo_property #(
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 4,
  parameter int  DROP_W = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst,
  input logic              validi,
  input logic              ready_in,
  input logic              clr_ovf,
  input logic              valido,
  input logic [DATA_W-1:0] data_out,
  input logic [CNT_W-1:0]  count,
  input logic              full,
  input logic              empty,
  input logic              overflow,
  input logic [DROP_W-1:0] drop_cnt
);
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst, validi, ready_in, clr_ovf, valido, data_out,
                      count, full, empty, overflow, drop_cnt};

`ifdef CHECK_ALL
  a_not_full_and_empty: assert property (@(posedge clk) disable iff (rst) !(full && empty));
`elsif CHECK1
  a_not_full_and_empty: assert property (@(posedge clk) disable iff (rst) !(full && empty));
`endif
`ifdef CHECK_ALL
  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
`elsif CHECK2
  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
`endif
`ifdef CHECK_ALL
  a_zero_when_empty: assert property (@(posedge clk) disable iff (rst) !valido |-> data_out == '0);
`elsif CHECK3
  a_zero_when_empty: assert property (@(posedge clk) disable iff (rst) !valido |-> data_out == '0);
`endif
`ifdef CHECK_ALL
  a_drop_sets_overflow: assert property (@(posedge clk) disable iff (rst)
    (validi && full && !(valido && ready_in)) |=> overflow);
`elsif CHECK4
  a_drop_sets_overflow: assert property (@(posedge clk) disable iff (rst)
    (validi && full && !(valido && ready_in)) |=> overflow);
`endif
`ifdef CHECK_ALL
  a_valid_is_not_empty: assert property (@(posedge clk) disable iff (rst) valido == !empty);
`elsif CHECK5
  a_valid_is_not_empty: assert property (@(posedge clk) disable iff (rst) valido == !empty);
`endif
endmodule

`ifdef CHECK_ALL
bind mac_result_fifo mac_result_fifo_property #(
  .DATA_W (DATA_W),
  .DEPTH  (DEPTH),
  .DROP_W (DROP_W)
) u_property (
  .clk      (clk),
  .rst      (rst),
  .validi   (validi),
  .ready_in (ready_in),
  .clr_ovf  (clr_ovf),
  .valido   (valido),
  .data_out (data_out),
  .count    (count),
  .full     (full),
  .empty    (empty),
  .overflow (overflow),
  .drop_cnt (drop_cnt)
);
`endif

// File: rtl/mac_result_fifo.sv
// First-word-fall-through buffer behind the MAC; words arriving while full are dropped,
// flagged sticky and counted, since the MAC cannot be stalled.
module mac_result_fifo
  import mac_pkg::*;
#(
  parameter int  DATA_W = MAC_DATA_W,
  parameter int  DEPTH  = 4,
  parameter int  DROP_W = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validi,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready_in,
  output logic              valido,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  input  logic              clr_ovf,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [DATA_W-1:0] w_rd_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = !w_empty && ready_in;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign w_push  = validi && (!w_full || w_pop);
  assign w_drop  = validi && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // A drop coinciding with clr_ovf restarts the tally at one rather than losing the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf) begin
        r_drop_cnt <= DROP_W'(1);
      end else if (r_drop_cnt != '1) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  mac_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign valido   = !w_empty;
  assign data_out = w_empty ? '0 : w_rd_data;
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;
endmodule
